// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit 5-stage pipeline: opcodes, widths and the
// LM/SM sequencer state encoding.
package risc_pkg;

  localparam int XLEN = 16;
  localparam int NREG = 8;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/lsb_pick8.sv
// Lowest-set-bit encoder for an 8-bit register list: binary index, one-hot
// isolation of that bit, and a flag for "exactly one bit set".
module lsb_pick8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic [7:0] onehot,
  output logic       single
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

  assign onehot = vec & (~vec + 8'd1);
  assign single = (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM in decode into one LW/SW-style micro-op per cycle, ascending
// R0..R7, while stalling fetch/decode until the last micro-op is accepted.
module lmsm_sequencer
  import risc_pkg::*;
#(
  parameter int XLEN = risc_pkg::XLEN,
  parameter int NREG = risc_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [15:0]     id_instr,
  input  logic [XLEN-1:0] id_base,
  input  logic            hold,
  input  logic            flush,
  output logic            stall_front,
  output logic            seq_take,
  output logic            uop_valid,
  output logic            uop_load,
  output logic [2:0]      uop_reg,
  output logic [XLEN-1:0] uop_addr,
  output logic            uop_last
);

  localparam int CW = $clog2(NREG);

  seq_state_e      state_q, state_d;
  logic [NREG-1:0] mask_q, mask_d;
  logic [XLEN-1:0] base_q, base_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_load_q, is_load_d;

  logic [3:0]      opcode;
  logic [NREG-1:0] list;
  logic            is_lmsm;
  logic            run;
  logic            accept;
  logic [2:0]      pick_idx;
  logic [7:0]      pick_onehot;
  logic            pick_single;
  logic            unused_instr_bits;

  assign opcode            = id_instr[15:12];
  assign list              = id_instr[NREG-1:0];
  assign is_lmsm           = (opcode == OP_LM) || (opcode == OP_SM);
  assign unused_instr_bits = ^id_instr[11:NREG];
  assign run               = (state_q == SEQ_RUN);

  lsb_pick8 u_pick (
    .vec    (mask_q),
    .idx    (pick_idx),
    .onehot (pick_onehot),
    .single (pick_single)
  );

  // Reset gates the take so every output reads 0 while rst is low.
  assign seq_take    = rst & ~run & id_valid & is_lmsm & ~hold & ~flush;
  assign stall_front = seq_take | (run & ~(pick_single & ~hold));

  assign uop_valid = run & ~flush;
  assign uop_load  = run & is_load_q;
  assign uop_reg   = run ? pick_idx : 3'd0;
  assign uop_addr  = run ? (base_q + XLEN'(cnt_q)) : '0;
  assign uop_last  = run & pick_single;
  assign accept    = uop_valid & ~hold;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    if (seq_take) begin
      mask_d    = list;
      base_d    = id_base;
      is_load_d = (opcode == OP_LM);
      cnt_d     = '0;
      state_d   = (list != '0) ? SEQ_RUN : SEQ_IDLE;
    end else if (run && flush) begin
      // Flush wins over hold and abandons the rest of the list.
      mask_d  = '0;
      state_d = SEQ_IDLE;
    end else if (accept) begin
      mask_d = mask_q & ~pick_onehot;
      cnt_d  = cnt_q + 1'b1;
      if (pick_single) state_d = SEQ_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SEQ_IDLE;
      mask_q    <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: per-cycle input vectors with hand-computed
// expected output words, one task per scenario.
module tb_lmsm_sequencer;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_base;
  logic        hold;
  logic        flush;
  logic        stall_front;
  logic        seq_take;
  logic        uop_valid;
  logic        uop_load;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;
  logic        uop_last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [15:0] instr;
    logic [15:0] base;
    logic        h;
    logic        f;
    logic [23:0] exp;
  } vec_t;

  lmsm_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_base     (id_base),
    .hold        (hold),
    .flush       (flush),
    .stall_front (stall_front),
    .seq_take    (seq_take),
    .uop_valid   (uop_valid),
    .uop_load    (uop_load),
    .uop_reg     (uop_reg),
    .uop_addr    (uop_addr),
    .uop_last    (uop_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed as {stall_front, seq_take, uop_valid, uop_load, uop_reg, uop_addr, uop_last}.
  logic [23:0] obs;
  assign obs = {stall_front, seq_take, uop_valid, uop_load, uop_reg, uop_addr, uop_last};

  function automatic logic [23:0] ex(input logic st, input logic tk, input logic vl,
                                     input logic ld, input logic [2:0] r,
                                     input logic [15:0] a, input logic lst);
    return {st, tk, vl, ld, r, a, lst};
  endfunction

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [7:0] lst);
    return {op, 3'd1, 1'b0, lst};
  endfunction

  function automatic vec_t vc(input logic v, input logic [15:0] instr, input logic [15:0] base,
                              input logic h, input logic f, input logic [23:0] e);
    vec_t t;
    t.v = v; t.instr = instr; t.base = base; t.h = h; t.f = f; t.exp = e;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v;
    id_instr = t.instr;
    id_base  = t.base;
    hold     = t.h;
    flush    = t.f;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(vc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 24'h0));
    #1;
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_state got %h want %h", obs, 24'h0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lm_basic();
    vec_t tbl[$];
    tbl.push_back(vc(1, ins(4'b0110, 8'h25), 16'h0100, 0, 0, ex(1, 1, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 1, 3'd0, 16'h0100, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 1, 3'd2, 16'h0101, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 1, 1, 3'd5, 16'h0102, 1)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      checks++;
      if (obs !== tbl[i].exp) begin
        errors++;
        $display("[TB] FAIL lm_basic cycle %0d got %h want %h", i, obs, tbl[i].exp);
      end
    end
  endtask

  task automatic test_sm_empty();
    vec_t tbl[$];
    tbl.push_back(vc(1, ins(4'b0111, 8'h00), 16'h1234, 0, 0, ex(1, 1, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      checks++;
      if (obs !== tbl[i].exp) begin
        errors++;
        $display("[TB] FAIL sm_empty cycle %0d got %h want %h", i, obs, tbl[i].exp);
      end
    end
  endtask

  task automatic test_sm_hold_wrap();
    vec_t tbl[$];
    tbl.push_back(vc(1, ins(4'b0111, 8'hFF), 16'hFFFE, 0, 0, ex(1, 1, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 0, 3'd0, 16'hFFFE, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 1, 0, ex(1, 0, 1, 0, 3'd1, 16'hFFFF, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 1, 0, ex(1, 0, 1, 0, 3'd1, 16'hFFFF, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 0, 3'd1, 16'hFFFF, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 0, 3'd2, 16'h0000, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 0, 3'd3, 16'h0001, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 0, 3'd4, 16'h0002, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 0, 3'd5, 16'h0003, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 0, 3'd6, 16'h0004, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 1, 0, 3'd7, 16'h0005, 1)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      checks++;
      if (obs !== tbl[i].exp) begin
        errors++;
        $display("[TB] FAIL sm_hold_wrap cycle %0d got %h want %h", i, obs, tbl[i].exp);
      end
    end
  endtask

  task automatic test_lm_flush();
    vec_t tbl[$];
    tbl.push_back(vc(1, ins(4'b0110, 8'h0F), 16'h0200, 0, 0, ex(1, 1, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 1, 3'd0, 16'h0200, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 1, 1, ex(1, 0, 0, 1, 3'd1, 16'h0201, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      checks++;
      if (obs !== tbl[i].exp) begin
        errors++;
        $display("[TB] FAIL lm_flush cycle %0d got %h want %h", i, obs, tbl[i].exp);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t pre[$];
    vec_t post[$];
    pre.push_back(vc(1, ins(4'b0110, 8'hF0), 16'h0300, 0, 0, ex(1, 1, 0, 0, 3'd0, 16'h0000, 0)));
    pre.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 1, 3'd4, 16'h0300, 0)));
    pre.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 1, 3'd5, 16'h0301, 0)));
    foreach (pre[i]) begin
      @(negedge clk);
      drive(pre[i]);
      #1;
      checks++;
      if (obs !== pre[i].exp) begin
        errors++;
        $display("[TB] FAIL async_pre cycle %0d got %h want %h", i, obs, pre[i].exp);
      end
    end
    // Mid-cycle, well before the next rising edge.
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_outputs got %h want %h", obs, 24'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    post.push_back(vc(1, ins(4'b0110, 8'h0A), 16'h0010, 0, 0, ex(1, 1, 0, 0, 3'd0, 16'h0000, 0)));
    post.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 1, 3'd1, 16'h0010, 0)));
    post.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 1, 1, 3'd3, 16'h0011, 1)));
    post.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    foreach (post[i]) begin
      @(negedge clk);
      drive(post[i]);
      #1;
      checks++;
      if (obs !== post[i].exp) begin
        errors++;
        $display("[TB] FAIL async_post cycle %0d got %h want %h", i, obs, post[i].exp);
      end
    end
  endtask

  task automatic test_idle_blocks();
    vec_t tbl[$];
    tbl.push_back(vc(1, 16'h0123, 16'h0040, 0, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(1, ins(4'b0110, 8'h03), 16'h0040, 1, 1, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(1, ins(4'b0110, 8'h03), 16'h0040, 1, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      checks++;
      if (obs !== tbl[i].exp) begin
        errors++;
        $display("[TB] FAIL idle_blocks cycle %0d got %h want %h", i, obs, tbl[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t tbl[$];
    tbl.push_back(vc(1, ins(4'b0110, 8'h81), 16'h0400, 0, 0, ex(1, 1, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(1, 0, 1, 1, 3'd0, 16'h0400, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 1, 1, 3'd7, 16'h0401, 1)));
    tbl.push_back(vc(1, ins(4'b0110, 8'h02), 16'h0500, 0, 0, ex(1, 1, 0, 0, 3'd0, 16'h0000, 0)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 1, 1, 3'd1, 16'h0500, 1)));
    tbl.push_back(vc(0, 16'h0, 16'h0, 0, 0, ex(0, 0, 0, 0, 3'd0, 16'h0000, 0)));
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      checks++;
      if (obs !== tbl[i].exp) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d got %h want %h", i, obs, tbl[i].exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lm_basic();
    test_sm_empty();
    test_sm_hold_wrap();
    test_lm_flush();
    test_async_reset();
    test_idle_blocks();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
